and_chain_sched: RTL and testbench

AND_CHAIN_SCHED -- requirements
Module: and_chain_sched

---
 rtl/and_chain_sched.sv | 177 +++++++++++++++++
 tb/tb_and_chain_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/and_chain_sched.sv
`default_nettype none
// ============================================================================
//  Module      : and_chain_sched
//  Description : Round-robin scheduler that hands a shared AND-chain resource
//                to one of NLANES requesting lanes for a bounded burst of
//                beats, with early release and a one-cycle gap between grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module and_chain_sched #(
  parameter int NLANES = 5,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NLANES-1:0] req,
  input  logic [NLANES-1:0] rel,
  input  logic [LEN_W-1:0]  burst_len,
  output logic [NLANES-1:0] gnt,
  output logic [2:0]        lane_id,
  output logic [LEN_W-1:0]  beat_cnt,
  output logic              last,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [NLANES-1:0] c_ONE_HOT0  = {{(NLANES-1){1'b0}}, 1'b1};
  localparam logic [2:0]        c_LAST_LANE = 3'(NLANES - 1);

  // Registered state and outputs
  state_t              r_state;
  logic [2:0]          r_ptr;
  logic [LEN_W-1:0]    r_len_q;
  logic [NLANES-1:0]   r_gnt;
  logic [2:0]          r_lane_id;
  logic [LEN_W-1:0]    r_beat_cnt;
  logic                r_last;
  logic                r_busy;

  // Next-state values
  state_t              w_state_nxt;
  logic [2:0]          w_ptr_nxt;
  logic [LEN_W-1:0]    w_len_nxt;
  logic [NLANES-1:0]   w_gnt_nxt;
  logic [2:0]          w_lane_nxt;
  logic [LEN_W-1:0]    w_beat_nxt;
  logic                w_last_nxt;
  logic                w_busy_nxt;

  // Arbitration results
  logic                w_found;
  logic [2:0]          w_win;
  logic [3:0]          w_idx;

  // Granted lane's own request / release bits (gnt is one-hot)
  logic                w_hold_req;
  logic                w_rel_hit;
  logic [LEN_W-1:0]    w_beat_inc;
  logic [2:0]          w_ptr_after;

  assign w_hold_req  = |(req & r_gnt);
  assign w_rel_hit   = |(rel & r_gnt);
  assign w_beat_inc  = r_beat_cnt + LEN_W'(1);
  assign w_ptr_after = (r_lane_id == c_LAST_LANE) ? 3'd0 : (r_lane_id + 3'd1);

  // Round-robin search upward from ptr, wrapping NLANES-1 -> 0
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = 4'd0;
    for (int k = 0; k < NLANES; k++) begin
      w_idx = {1'b0, r_ptr} + 4'(k);
      if (w_idx >= 4'(NLANES)) begin
        w_idx = w_idx - 4'(NLANES);
      end
      if (!w_found && req[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[2:0];
      end
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_len_nxt   = r_len_q;
    w_gnt_nxt   = r_gnt;
    w_lane_nxt  = r_lane_id;
    w_beat_nxt  = r_beat_cnt;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;

    case (r_state)
      S_IDLE, S_GAP: begin
        if (w_found) begin
          // Start a new grant; burst length is captured once here
          w_state_nxt = S_RUN;
          w_len_nxt   = burst_len;
          w_gnt_nxt   = c_ONE_HOT0 << w_win;
          w_lane_nxt  = w_win;
          w_beat_nxt  = '0;
          w_last_nxt  = (burst_len == '0);
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_lane_nxt  = 3'd0;
          w_beat_nxt  = '0;
          w_last_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      end

      S_RUN: begin
        if (r_last || w_rel_hit || !w_hold_req) begin
          // Grant ends: the lane after the released one gets first look
          w_state_nxt = S_GAP;
          w_ptr_nxt   = w_ptr_after;
          w_gnt_nxt   = '0;
          w_lane_nxt  = 3'd0;
          w_beat_nxt  = '0;
          w_last_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
        end else begin
          // beat_cnt never passes len_q, so it cannot wrap
          w_beat_nxt  = w_beat_inc;
          w_last_nxt  = (w_beat_inc == r_len_q);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_lane_nxt  = 3'd0;
        w_beat_nxt  = '0;
        w_last_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 3'd0;
      r_len_q    <= '0;
      r_gnt      <= '0;
      r_lane_id  <= 3'd0;
      r_beat_cnt <= '0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_len_q    <= w_len_nxt;
      r_gnt      <= w_gnt_nxt;
      r_lane_id  <= w_lane_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_last     <= w_last_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign lane_id  = r_lane_id;
  assign beat_cnt = r_beat_cnt;
  assign last     = r_last;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_and_chain_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_and_chain_sched
//  Description : Directed scoreboard bench for and_chain_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_and_chain_sched;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic [4:0] rel;
  logic [3:0] burst_len;
  logic [4:0] gnt;
  logic [2:0] lane_id;
  logic [3:0] beat_cnt;
  logic       last;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0] lane;
    logic [3:0] beat;
    logic       last;
  } beat_t;

  beat_t exp_q[$];

  and_chain_sched #(.NLANES(5), .LEN_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .burst_len (burst_len),
    .gnt       (gnt),
    .lane_id   (lane_id),
    .beat_cnt  (beat_cnt),
    .last      (last),
    .busy      (busy)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue the expected beats of one grant
  task automatic exp_burst(input int lane, input int nbeats, input bit ends_last);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.lane = 3'(lane);
      b.beat = 4'(i);
      b.last = ends_last && (i == nbeats - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Direct comparison of every output against required values
  task automatic chk_out(input string name, input logic [4:0] e_gnt, input logic [2:0] e_lane,
                         input logic [3:0] e_beat, input logic e_last, input logic e_busy);
    n_checks++;
    if (gnt !== e_gnt || lane_id !== e_lane || beat_cnt !== e_beat ||
        last !== e_last || busy !== e_busy) begin
      n_errors++;
      $display("FAIL %s: got gnt=%b lane=%0d beat=%0d last=%b busy=%b, want gnt=%b lane=%0d beat=%0d last=%b busy=%b",
               name, gnt, lane_id, beat_cnt, last, busy, e_gnt, e_lane, e_beat, e_last, e_busy);
    end
  endtask

  task automatic chk_idle(input string name);
    chk_out(name, 5'b0, 3'd0, 4'd0, 1'b0, 1'b0);
  endtask

  // Monitor: every presented beat is matched against the scoreboard head
  always @(negedge clk) begin
    if (busy || gnt != 5'b0) begin
      beat_t      e;
      logic [4:0] one;
      logic [4:0] e_gnt;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL beat_unexpected: got gnt=%b lane=%0d beat=%0d last=%b, want no grant",
                 gnt, lane_id, beat_cnt, last);
      end else begin
        e     = exp_q.pop_front();
        one   = 5'd1;
        e_gnt = one << e.lane;
        if (gnt !== e_gnt || lane_id !== e.lane || beat_cnt !== e.beat ||
            last !== e.last || busy !== 1'b1) begin
          n_errors++;
          $display("FAIL beat: got gnt=%b lane=%0d beat=%0d last=%b busy=%b, want gnt=%b lane=%0d beat=%0d last=%b busy=1",
                   gnt, lane_id, beat_cnt, last, busy, e_gnt, e.lane, e.beat, e.last);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req       = 5'b0;
    rel       = 5'b0;
    burst_len = 4'd0;
    #2;
    chk_idle("reset_state");
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk_idle("idle_no_req");

    // Lane 2 alone, 3-beat bursts, re-granted after one gap cycle;
    // burst_len change mid-grant must be ignored
    req       = 5'b00100;
    burst_len = 4'd2;
    exp_burst(2, 3, 1'b1);
    exp_burst(2, 3, 1'b1);
    tick(1);
    burst_len = 4'd0;
    tick(2);
    burst_len = 4'd2;
    tick(1);
    chk_idle("s1_gap");
    tick(3);
    req = 5'b0;
    tick(1);
    chk_idle("s1_gap2");
    tick(1);

    // Fresh reset, then all lanes requesting with single-beat grants
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req       = 5'b11111;
    burst_len = 4'd0;
    exp_burst(0, 1, 1'b1);
    exp_burst(1, 1, 1'b1);
    exp_burst(2, 1, 1'b1);
    exp_burst(3, 1, 1'b1);
    exp_burst(4, 1, 1'b1);
    exp_burst(0, 1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (i < 5) begin
        tick(1);
        chk_idle("s2_gap");
      end
    end
    req = 5'b0;
    tick(1);
    tick(1);

    // Lane 3 released early at beat 2; next winner searched from lane 4
    req       = 5'b01000;
    burst_len = 4'd7;
    exp_burst(3, 3, 1'b0);
    exp_burst(4, 1, 1'b1);
    tick(3);
    rel       = 5'b01000;
    req       = 5'b11010;
    burst_len = 4'd0;
    tick(1);
    rel = 5'b0;
    chk_idle("s3_gap");
    tick(1);
    req = 5'b0;
    tick(1);
    tick(1);

    // Release bit of a non-granted lane has no effect
    req       = 5'b00010;
    rel       = 5'b00001;
    burst_len = 4'd3;
    exp_burst(1, 4, 1'b1);
    tick(4);
    req = 5'b0;
    tick(1);
    chk_idle("s4_gap");
    tick(1);
    rel = 5'b0;

    // Dropping req ends the grant without last
    req       = 5'b01000;
    burst_len = 4'd7;
    exp_burst(3, 2, 1'b0);
    tick(2);
    req = 5'b0;
    tick(1);
    chk_idle("s7_gap");
    tick(1);

    // Asynchronous reset during beat 1 of a lane-2 grant
    req       = 5'b00100;
    burst_len = 4'd5;
    exp_burst(2, 1, 1'b0);
    tick(2);
    chk_out("s5_beat1", 5'b00100, 3'd2, 4'd1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("s5_async_reset");
    req       = 5'b10010;
    burst_len = 4'd1;
    exp_burst(1, 2, 1'b1);
    #1;
    rst_n = 1'b1;
    tick(2);
    req = 5'b0;
    tick(1);
    chk_idle("s5_gap");
    tick(1);

    // Maximum burst length: beats 0..15, no wrap
    req       = 5'b00001;
    burst_len = 4'd15;
    exp_burst(0, 16, 1'b1);
    tick(16);
    req = 5'b0;
    tick(1);
    chk_idle("s6_gap");
    tick(2);
    chk_idle("final_idle");

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d beats never seen, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
